// File: rtl/csr_issue_queue_if.sv
// Dispatch-side bus of the CSR issue queue. The dispatch/bench side connects
// through the master modport; the queue itself connects through slave.
//
// Push handshake: dispatch raises i_drive_1 with i_instruction_113 stable;
// the queue raises o_free_1 when it can take it. A push happens on the clk
// edge where both are high. i_drive_1 may stay high across a cycle in which
// o_free_1 is low, and the instruction must then be held until it is taken.
interface csr_issue_queue_if #(
  parameter int DEPTH = 16,
  parameter int IW    = 113
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic                  i_drive_1;
  logic                  o_free_1;
  logic [IW-1:0]         i_instruction_113;
  logic                  i_flush_1;
  logic [PW-1:0]         i_RdPtrGray_5;
  logic [PW-1:0]         o_WrPtrGray_5;
  logic [DEPTH*IW-1:0]   o_Entries_1808;
  logic                  o_full_1;
  logic [PW-1:0]         o_level_5;

  modport master (
    output i_drive_1, i_instruction_113, i_flush_1, i_RdPtrGray_5,
    input  o_free_1, o_WrPtrGray_5, o_Entries_1808, o_full_1, o_level_5
  );

  modport slave (
    input  i_drive_1, i_instruction_113, i_flush_1, i_RdPtrGray_5,
    output o_free_1, o_WrPtrGray_5, o_Entries_1808, o_full_1, o_level_5
  );
endinterface

// File: rtl/csr_issue_queue.sv
// Write side of the CSR instruction queue. Stores dispatched instructions in
// a circular buffer, publishes a gray write pointer to the issue stage and
// derives full/level from the issue stage's synchronised gray read pointer.
// There is no FSM; the only state is the entry array, the pointers and the
// read-pointer synchroniser.
module csr_issue_queue #(
  parameter int DEPTH = 16,
  parameter int IW    = 113
) (
  input logic              clk,
  input logic              rstn,
  csr_issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wb;
  logic [PW-1:0] wg;
  logic [PW-1:0] s1;
  logic [PW-1:0] s2;
  logic [PW-1:0] rb;
  logic [PW-1:0] wb_inc;
  logic          full;
  logic          push;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign rb     = gray2bin(s2);
  // Full when the write pointer is exactly one lap ahead of the synchronised
  // read pointer: the top two gray bits differ, the rest match.
  assign full   = (wg == {~s2[PW-1:PW-2], s2[PW-3:0]});
  // A flush takes priority, so nothing is accepted in the flush cycle.
  assign push   = bus.i_drive_1 && !full && !bus.i_flush_1;
  assign wb_inc = wb + 1'b1;

  assign bus.o_full_1      = full;
  assign bus.o_free_1      = !full && !bus.i_flush_1;
  assign bus.o_level_5     = wb - rb;
  assign bus.o_WrPtrGray_5 = wg;

  // Two-flop synchroniser for the issue-stage gray read pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.i_RdPtrGray_5;
      s2 <= s1;
    end
  end

  // Write pointer: flush snaps it onto the synchronised read pointer,
  // otherwise it advances by one per accepted push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb <= '0;
      wg <= '0;
    end else if (bus.i_flush_1) begin
      wb <= rb;
      wg <= s2;
    end else if (push) begin
      wb <= wb_inc;
      wg <= wb_inc ^ (wb_inc >> 1);
    end
  end

  // Entry array: written at the same edge the pointer moves, never cleared
  // by a flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (push) begin
      mem[wb[AW-1:0]] <= bus.i_instruction_113;
    end
  end

  // Flat view of all slots, slot k on bits [IW*k +: IW].
  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign bus.o_Entries_1808[k*IW +: IW] = mem[k];
  end
endmodule

// File: tb/tb_csr_issue_queue.sv
// Bench for csr_issue_queue: directed scenarios plus randomized traffic,
// checked against a queue-level model of the write side and an emulated
// issue stage that consumes entries in order.
module tb_csr_issue_queue;
  localparam int DEPTH = 16;
  localparam int IW    = 113;
  localparam int PW    = 5;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  csr_issue_queue_if #(.DEPTH(DEPTH), .IW(IW)) bus ();

  csr_issue_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ---------------- model / scoreboard ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [IW-1:0] m_mem [DEPTH];
  logic [IW-1:0] exp_q [$];
  int            m_w;
  int            m_r;
  int            m_s1;
  int            m_s2;

  function automatic int g2b(int g);
    int b = 0;
    for (int s = 0; s < PW; s++) b = b ^ (g >> s);
    return b & 31;
  endfunction

  function automatic int b2g(int b);
    return (b ^ (b >> 1)) & 31;
  endfunction

  function automatic int m_level();
    return (m_w - g2b(m_s2)) & 31;
  endfunction

  function automatic bit m_full();
    return m_level() == DEPTH;
  endfunction

  function automatic logic [IW-1:0] slot(int k);
    return bus.o_Entries_1808[k*IW +: IW];
  endfunction

  function automatic logic [IW-1:0] rand_instr();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    return v[IW-1:0];
  endfunction

  task automatic check(input string tag, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_r = 0; m_s1 = 0; m_s2 = 0;
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".gray"},  IW'(bus.o_WrPtrGray_5), IW'(b2g(m_w)));
    check({tag, ".full"},  IW'(bus.o_full_1),      IW'(m_full()));
    check({tag, ".level"}, IW'(bus.o_level_5),     IW'(m_level()));
    check({tag, ".free"},  IW'(bus.o_free_1),      IW'(!m_full() && !bus.i_flush_1));
    check({tag, ".cons"},  IW'(int'(bus.o_level_5) >= exp_q.size()), IW'(1));
    for (int k = 0; k < DEPTH; k++)
      check($sformatf("%s.slot%0d", tag, k), slot(k), m_mem[k]);
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge; model follows the queue rules with the inputs present
  // just before the edge, then outputs are compared 1 time unit later.
  task automatic tick(input string tag);
    bit            do_flush;
    bit            do_push;
    int            rd;
    logic [IW-1:0] ins;
    do_flush = bus.i_flush_1;
    do_push  = bus.i_drive_1 && !m_full() && !do_flush;
    rd       = int'(bus.i_RdPtrGray_5);
    ins      = bus.i_instruction_113;
    @(posedge clk);
    if (do_flush) begin
      m_w = g2b(m_s2);
      exp_q.delete();
    end else if (do_push) begin
      m_mem[m_w % DEPTH] = ins;
      exp_q.push_back(ins);
      m_w = (m_w + 1) & 31;
    end
    m_s2 = m_s1;
    m_s1 = rd;
    #1;
    check_all(tag);
  endtask

  // Issue stage consumes the oldest unread entry and publishes its pointer.
  task automatic rd_advance();
    if (exp_q.size() > 0) begin
      check("rd_data", slot(m_r % DEPTH), exp_q.pop_front());
      m_r = (m_r + 1) & 31;
      bus.i_RdPtrGray_5 = PW'(b2g(m_r));
    end
  endtask

  task automatic hard_reset();
    bus.i_drive_1 = 1'b0;
    bus.i_flush_1 = 1'b0;
    bus.i_RdPtrGray_5 = '0;
    #2 rstn = 1'b0;
    #1 model_reset();
    check_all("reset");
    #2 rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int            prev_g;
  int            prev_lvl;
  int            budget;
  logic [IW-1:0] tmp;

  initial begin
    bus.i_drive_1         = 1'b0;
    bus.i_flush_1         = 1'b0;
    bus.i_RdPtrGray_5     = '0;
    bus.i_instruction_113 = '0;
    #1 model_reset();
    check_all("init");
    #10 rstn = 1'b1;

    // Fill: value k into slot k, reader idle.
    for (int k = 0; k < DEPTH; k++) begin
      bus.i_drive_1 = 1'b1;
      bus.i_instruction_113 = IW'(k);
      tick("fill");
    end
    check("fill.gray16", IW'(bus.o_WrPtrGray_5), IW'(5'b11000));
    check("fill.full16", IW'(bus.o_full_1), IW'(1));
    check("fill.lvl16",  IW'(bus.o_level_5), IW'(16));
    check("fill.free16", IW'(bus.o_free_1), IW'(0));
    check("fill.slot5",  slot(5), IW'(5));
    bus.i_instruction_113 = IW'(99);
    tick("hold17");
    check("hold17.gray", IW'(bus.o_WrPtrGray_5), IW'(5'b11000));

    // Release one slot: two edges before full drops.
    bus.i_drive_1 = 1'b0;
    rd_advance();
    tick("rel1");
    check("rel1.full", IW'(bus.o_full_1), IW'(1));
    tick("rel2");
    check("rel2.full", IW'(bus.o_full_1), IW'(0));
    check("rel2.lvl",  IW'(bus.o_level_5), IW'(15));
    bus.i_drive_1 = 1'b1;
    bus.i_instruction_113 = IW'(16);
    tick("rel.push");
    check("rel.slot0", slot(0), IW'(16));
    check("rel.gray",  IW'(bus.o_WrPtrGray_5), IW'(5'b11001));

    // Wrap: keep pushing with the reader tracking until 32 pushes total.
    budget = 200;
    prev_g = int'(bus.o_WrPtrGray_5);
    while (m_w != 0 && budget > 0) begin
      bus.i_instruction_113 = rand_instr();
      tick("wrap");
      if (int'(bus.o_WrPtrGray_5) != prev_g)
        check("wrap.onebit", IW'($countones(PW'(prev_g) ^ bus.o_WrPtrGray_5)), IW'(1));
      prev_g = int'(bus.o_WrPtrGray_5);
      rd_advance();
      budget--;
    end
    check("wrap.gray0", IW'(bus.o_WrPtrGray_5), IW'(0));
    bus.i_drive_1 = 1'b0;

    // Flush: wb=9, reader at 5 and settled, flush with drive high.
    hard_reset();
    for (int k = 0; k < 9; k++) begin
      bus.i_drive_1 = 1'b1;
      bus.i_instruction_113 = rand_instr();
      tick("fl.fill");
    end
    bus.i_drive_1 = 1'b0;
    for (int k = 0; k < 5; k++) rd_advance();
    check("fl.rdgray", IW'(bus.i_RdPtrGray_5), IW'(5'b00111));
    for (int k = 0; k < 3; k++) tick("fl.settle");
    check("fl.gray9", IW'(bus.o_WrPtrGray_5), IW'(5'b01101));
    check("fl.lvl4",  IW'(bus.o_level_5), IW'(4));
    tmp = slot(9);
    bus.i_flush_1 = 1'b1;
    bus.i_drive_1 = 1'b1;
    bus.i_instruction_113 = rand_instr();
    #1 check("fl.free", IW'(bus.o_free_1), IW'(0));
    tick("flush");
    bus.i_flush_1 = 1'b0;
    bus.i_drive_1 = 1'b0;
    check("fl.gray", IW'(bus.o_WrPtrGray_5), IW'(5'b00111));
    check("fl.lvl0", IW'(bus.o_level_5), IW'(0));
    check("fl.slot9", slot(9), tmp);
    tick("fl.after");

    // Gray synchroniser: full, then reader steps through gray 0..16
    // mid-cycle; level must never rise without a push.
    hard_reset();
    for (int k = 0; k < DEPTH; k++) begin
      bus.i_drive_1 = 1'b1;
      bus.i_instruction_113 = rand_instr();
      tick("gs.fill");
    end
    bus.i_drive_1 = 1'b0;
    prev_lvl = int'(bus.o_level_5);
    for (int k = 0; k < DEPTH + 3; k++) begin
      tick("gs.step");
      check("gs.mono", IW'(int'(bus.o_level_5) <= prev_lvl), IW'(1));
      prev_lvl = int'(bus.o_level_5);
      #3 rd_advance();
    end
    check("gs.lvl0", IW'(bus.o_level_5), IW'(0));

    // Randomized traffic with an in-order consumer.
    for (int c = 0; c < 400; c++) begin
      bus.i_drive_1 = ($urandom_range(0, 3) != 0);
      bus.i_instruction_113 = rand_instr();
      tick("rnd");
      if ($urandom_range(0, 2) == 0) rd_advance();
    end

    // Reset asserted mid-push: outputs clear immediately.
    bus.i_drive_1 = 1'b1;
    bus.i_instruction_113 = rand_instr();
    tick("pre_rst");
    #1 rstn = 1'b0;
    #1 model_reset();
    check_all("mid_rst");
    check("mid_rst.free", IW'(bus.o_free_1), IW'(1));
    check("mid_rst.gray", IW'(bus.o_WrPtrGray_5), IW'(0));
    bus.i_drive_1 = 1'b0;
    bus.i_RdPtrGray_5 = '0;
    #2 rstn = 1'b1;
    tick("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
